mux_tree_pipe: RTL and testbench
================================

Name: mux_tree_pipe

Overview:
- Parametrised N-input, W-bit selector built as a radix-4 tree of registered 4:1 stages.
- Replaces hand-instantiated 1-bit 4:1 muxes in the cosine/LUT datapath of the functional-link filters.
- Carries a valid flag and the select bits alongside the data through the pipeline.
- Supports stall (ce) and flush, so it can sit directly in the LMS weight-update and expansion pipelines.

Parameters:
- NUM_IN, 16: number of data inputs, 2..256.
- WIDTH, 16: bits per data input.
- REG_LEVELS, 1: 1 = register after every tree level; 0 = combinational tree with a single output register.
- LEVELS, derived = ceil(log4(NUM_IN)), minimum 1. Localparam, not overridable.
- SEL_W, derived = 2*LEVELS. Localparam.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable. Low freezes every pipeline register.
- flush  in  1  synchronous clear of all valid bits.
- in_data  in  NUM_IN*WIDTH  flattened inputs. Input k is in_data[k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  index of the input to select.
- in_valid  in  1  marks in_data/in_sel as meaningful this cycle.
- out_data  out  WIDTH  selected word.
- out_valid  out  1  out_data is valid.

Behaviour:
- Reset (rst high, asynchronous): all pipeline data, select and valid registers clear to 0. out_data=0 and out_valid=0 immediately, not waiting for a clock edge.
- Tree padding:
  - Inputs are zero-padded to 4^LEVELS.
  - Level j (0 = leaf) uses sel bits [2j+1:2j].
  - Any in_sel >= NUM_IN yields out_data=0. This is not an error.
- Latency: LAT = LEVELS if REG_LEVELS=1, else 1. A sample accepted at edge t (ce=1) appears at out_data/out_valid after edge t+LAT-1, i.e. LAT cycles after presentation.
- Stage registers (REG_LEVELS=1):
  - Each stage holds its partial words, the remaining upper sel bits and a valid bit.
  - Data and sel registers load whenever ce=1, regardless of valid.
  - Valid register loads the previous stage's valid.
- ce=0: every register holds, and out_data/out_valid are stable. No sample is lost or duplicated across any stall length.
- flush=1 on a clock edge:
  - All valid bits become 0. Data registers follow normal ce rules.
  - flush overrides ce=0: valid bits clear even while stalled.
  - A sample presented in the flush cycle is discarded.
- in_valid=0 samples propagate as bubbles; out_valid is 0 for them.
- Back-to-back samples: throughput is 1 sample per cycle with ce held high.
- rst asserted mid-stream: in-flight samples are lost, not recovered. The first valid output after release is LAT cycles after the first post-reset in_valid.
- LEVELS=1 (NUM_IN<=4): single 4:1 stage plus one register. LAT=1 in both modes.
- No arithmetic; data passes bit-exact.

Decomposition:
- Shared package/header (flaf_pkg) holds:
  - a clog4 constant function;
  - the flattened-bus index macro;
  - the LAT formula, for reuse by upstream delay-matching blocks.
- One sub-module, mux4_stage:
  - WIDTH-bit 4:1 mux with optional output register (param REG) plus valid/sel pass-through.
  - Instantiated in a generate loop, 4^(LEVELS-1-j) instances at level j.
- Top level handles padding, sel slicing, flush/ce fan-out and the final output register when REG_LEVELS=0.

Test Plan:
1. Path and latency sweep. NUM_IN=16, WIDTH=8, REG_LEVELS=1, in_data[k]=8'h10+k. Sweep in_sel 0..15 back-to-back with in_valid=1 → out_data = 8'h10..8'h1F in order, out_valid=1 from the 2nd cycle, LAT=2, no gaps.
2. Padding. NUM_IN=6. in_sel=5 → 8'h15. in_sel=6, 7, 15 → out_data=8'h00 with out_valid=1.
3. Stall. Stream 4 samples, drop ce for 3 cycles after the 2nd edge → outputs frozen during the stall. All 4 values emerge exactly once, in order, with total delay LAT+3.
4. Flush. Samples in flight (sel=3, 9), flush=1 for one cycle with ce=0 → out_valid=0 on the next cycle. A new sample (sel=12) appears alone with out_valid=1 after LAT cycles.
5. Asynchronous reset. Assert rst mid-cycle between edges with pipeline full → out_data=0 and out_valid=0 before the next edge. After release, first output appears exactly LAT cycles after the first in_valid.
6. Single-register mode. REG_LEVELS=0, NUM_IN=64 (LEVELS=3), random sel/data for 1000 cycles → out_data matches the golden model delayed by 1 cycle, and valid alignment is exact.

Source files
------------

// File: rtl/flaf_pkg.sv
// Shared helpers for the functional-link filter datapath.
//   clog4     : ceiling log4, used to size radix-4 selector trees
//   lat       : pipeline latency of mux_tree_pipe, for upstream delay matching
//   FLAF_IDX  : part-select of word k from a flattened bus of w-bit words
`ifndef FLAF_PKG_SV
`define FLAF_PKG_SV

`define FLAF_IDX(k, w) (k)*(w) +: (w)

package flaf_pkg;

    // Number of radix-4 levels needed to cover n leaves (0 for n <= 1).
    function automatic int unsigned clog4(input int unsigned n);
        int unsigned     levels;
        longint unsigned span;
        levels = 0;
        span   = 1;
        for (int i = 0; i < 17; i++) begin
            if (span < 64'(n)) begin
                span   = span * 4;
                levels = levels + 1;
            end
        end
        return levels;
    endfunction

    // Cycles from presentation to output of mux_tree_pipe.
    function automatic int unsigned lat(input int unsigned levels, input int unsigned reg_levels);
        return (reg_levels != 0) ? levels : 1;
    endfunction

endpackage

`endif

// File: rtl/mux4_stage.sv
// One radix-4 node of the selector tree: WIDTH-bit 4:1 mux, optional
// output register, with the select word and valid flag carried alongside.
//   clk, rst      : clock, async active-high reset
//   ce, flush     : stall (hold all) and valid clear (wins over ce)
//   d_i           : four flattened WIDTH-bit candidates
//   sel_i, sel_o  : full select word in / carried out
//   valid_i/_o    : sample valid in / carried out
//   q_o           : selected word
module mux4_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned LVL   = 0,
    parameter bit          REG   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               flush,
    input  logic [4*WIDTH-1:0] d_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               valid_i,
    output logic [WIDTH-1:0]   q_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               valid_o
);

    logic [1:0]       leg_c;
    logic [WIDTH-1:0] data_d;

    // This level consumes its own two select bits; the rest ride along.
    always_comb begin
        leg_c  = sel_i[2*LVL +: 2];
        data_d = d_i[`FLAF_IDX(leg_c, WIDTH)];
    end

    generate
        if (REG) begin : g_reg
            logic [WIDTH-1:0] data_q;
            logic [SEL_W-1:0] sel_q;
            logic             valid_q;

            // Data/select follow ce only; valid additionally clears on flush.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    sel_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    if (ce) begin
                        data_q <= data_d;
                        sel_q  <= sel_i;
                    end
                    if (flush) begin
                        valid_q <= 1'b0;
                    end else if (ce) begin
                        valid_q <= valid_i;
                    end
                end
            end

            assign q_o     = data_q;
            assign sel_o   = sel_q;
            assign valid_o = valid_q;
        end else begin : g_comb
            // Clock-domain inputs have no role in a pass-through node.
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst, ce, flush};

            assign q_o     = data_d;
            assign sel_o   = sel_i;
            assign valid_o = valid_i;
        end
    endgenerate

endmodule

// File: rtl/mux_tree_pipe.sv
// Parametrised NUM_IN-input, WIDTH-bit selector built as a radix-4 tree
// of mux4_stage nodes, with valid and select carried through the pipe.
//   clk, rst  : clock, async active-high reset
//   ce        : clock enable, low freezes every register
//   flush     : clears all valid bits on an edge, even while stalled
//   in_data   : flattened inputs, word k at in_data[k*WIDTH +: WIDTH]
//   in_sel    : index of the word to select (>= NUM_IN selects zero)
//   in_valid  : sample qualifier
//   out_data  : selected word, out_valid marks it meaningful
module mux_tree_pipe
    import flaf_pkg::*;
#(
    parameter  int unsigned NUM_IN     = 16,
    parameter  int unsigned WIDTH      = 16,
    parameter  int unsigned REG_LEVELS = 1,
    localparam int unsigned LEVELS     = (clog4(NUM_IN) < 1) ? 1 : clog4(NUM_IN),
    localparam int unsigned SEL_W      = 2 * LEVELS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid
);

    localparam int unsigned NPAD      = 4 ** LEVELS;
    localparam bit          STAGE_REG = (REG_LEVELS != 0);

    logic [NPAD*WIDTH-1:0] padded_c;

    // Unused leaves read as zero, so out-of-range selects return zero.
    always_comb begin
        padded_c                   = '0;
        padded_c[NUM_IN*WIDTH-1:0] = in_data;
    end

    generate
        for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
            localparam int unsigned NI = 4 ** (LEVELS - j);
            localparam int unsigned NO = NI / 4;

            logic [NI*WIDTH-1:0] din;
            logic [SEL_W-1:0]    sin;
            logic                vin;
            logic [NO*WIDTH-1:0] dout;
            logic [NO*SEL_W-1:0] sout;
            logic [NO-1:0]       vout;

            if (j == 0) begin : g_src
                assign din = padded_c;
                assign sin = in_sel;
                assign vin = in_valid;
            end else begin : g_chain
                // Every node of a level carries the same select/valid copy;
                // node 0 feeds the next level.
                logic unused_copies;
                assign din           = g_lvl[j-1].dout;
                assign sin           = g_lvl[j-1].sout[SEL_W-1:0];
                assign vin           = g_lvl[j-1].vout[0];
                assign unused_copies = ^{g_lvl[j-1].sout, g_lvl[j-1].vout};
            end

            for (genvar i = 0; i < NO; i++) begin : g_node
                mux4_stage #(
                    .WIDTH (WIDTH),
                    .SEL_W (SEL_W),
                    .LVL   (j),
                    .REG   (STAGE_REG)
                ) u_stage (
                    .clk     (clk),
                    .rst     (rst),
                    .ce      (ce),
                    .flush   (flush),
                    .d_i     (din[i*4*WIDTH +: 4*WIDTH]),
                    .sel_i   (sin),
                    .valid_i (vin),
                    .q_o     (dout[`FLAF_IDX(i, WIDTH)]),
                    .sel_o   (sout[`FLAF_IDX(i, SEL_W)]),
                    .valid_o (vout[i])
                );
            end
        end

        // The root's carried select has no consumer.
        logic unused_root_sel;
        assign unused_root_sel = ^g_lvl[LEVELS-1].sout;

        if (STAGE_REG) begin : g_out_direct
            assign out_data  = g_lvl[LEVELS-1].dout;
            assign out_valid = g_lvl[LEVELS-1].vout[0];
        end else begin : g_out_reg
            logic [WIDTH-1:0] data_q;
            logic             valid_q;

            // Single register behind the combinational tree.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    if (ce) begin
                        data_q <= g_lvl[LEVELS-1].dout;
                    end
                    if (flush) begin
                        valid_q <= 1'b0;
                    end else if (ce) begin
                        valid_q <= g_lvl[LEVELS-1].vout[0];
                    end
                end
            end

            assign out_data  = data_q;
            assign out_valid = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Self-checking bench for mux_tree_pipe: three instances (16 inputs
// registered per level, 6 inputs with padding, 64 inputs single register)
// checked against a golden-select delay-line model.
module tb_mux_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, ce, flush;

    logic [16*8-1:0] d16; logic [3:0] s16; logic v16; logic [7:0] o16; logic ov16;
    logic [6*8-1:0]  d6;  logic [3:0] s6;  logic v6;  logic [7:0] o6;  logic ov6;
    logic [64*8-1:0] d64; logic [5:0] s64; logic v64; logic [7:0] o64; logic ov64;

    int checks   = 0;
    int failures = 0;

    // Model: golden selected words shifted along LAT slots per instance.
    logic [7:0] m16_d [2]; logic m16_v [2];
    logic [7:0] m6_d  [2]; logic m6_v  [2];
    logic [7:0] m64_d;     logic m64_v;

    mux_tree_pipe #(.NUM_IN(16), .WIDTH(8), .REG_LEVELS(1)) u_dut16 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_data(d16), .in_sel(s16), .in_valid(v16),
        .out_data(o16), .out_valid(ov16));

    mux_tree_pipe #(.NUM_IN(6), .WIDTH(8), .REG_LEVELS(1)) u_dut6 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_data(d6), .in_sel(s6), .in_valid(v6),
        .out_data(o6), .out_valid(ov6));

    mux_tree_pipe #(.NUM_IN(64), .WIDTH(8), .REG_LEVELS(0)) u_dut64 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush),
        .in_data(d64), .in_sel(s64), .in_valid(v64),
        .out_data(o64), .out_valid(ov64));

    function automatic logic [7:0] pick(input logic [511:0] data, input int n, input int sel);
        if (sel >= n) return 8'h00;
        return data[sel*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m16_d[k] = 8'h00; m16_v[k] = 1'b0;
            m6_d[k]  = 8'h00; m6_v[k]  = 1'b0;
        end
        m64_d = 8'h00; m64_v = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] g16, g6, g64;
        g16 = pick(512'(d16), 16, int'(s16));
        g6  = pick(512'(d6), 6, int'(s6));
        g64 = pick(d64, 64, int'(s64));
        if (ce) begin
            m16_d[1] = m16_d[0]; m16_v[1] = m16_v[0]; m16_d[0] = g16; m16_v[0] = v16;
            m6_d[1]  = m6_d[0];  m6_v[1]  = m6_v[0];  m6_d[0]  = g6;  m6_v[0]  = v6;
            m64_d    = g64;      m64_v    = v64;
        end
        if (flush) begin
            m16_v[0] = 1'b0; m16_v[1] = 1'b0;
            m6_v[0]  = 1'b0; m6_v[1]  = 1'b0;
            m64_v    = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_d16"}, o16, m16_d[1]);
        chk({tag, "_v16"}, 8'(ov16), 8'(m16_v[1]));
        chk({tag, "_d6"}, o6, m6_d[1]);
        chk({tag, "_v6"}, 8'(ov6), 8'(m6_v[1]));
        chk({tag, "_d64"}, o64, m64_d);
        chk({tag, "_v64"}, 8'(ov64), 8'(m64_v));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input int sel);
        v16 = v; s16 = 4'(sel);
        v6  = v; s6  = 4'(sel);
        v64 = v; s64 = 6'(sel);
    endtask

    logic [3:0] pad_sel [4] = '{4'd5, 4'd6, 4'd7, 4'd15};
    logic [7:0] pad_exp [4] = '{8'h15, 8'h00, 8'h00, 8'h00};
    bit         st_ce   [10] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
    bit         st_v    [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int         st_sel  [10] = '{2, 5, 8, 8, 8, 8, 11, 0, 0, 0};

    initial begin
        logic [7:0] q_seen [$];
        logic [7:0] held;
        int         lat16, lat64;

        rst = 1'b1; ce = 1'b0; flush = 1'b0;
        d16 = '0; d6 = '0; d64 = '0;
        drive(1'b0, 0);
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;

        for (int k = 0; k < 16; k++) d16[k*8 +: 8] = 8'(8'h10 + k);
        for (int k = 0; k < 6; k++)  d6[k*8 +: 8]  = 8'(8'h10 + k);
        for (int k = 0; k < 64; k++) d64[k*8 +: 8] = 8'(8'h40 + k);

        // Back-to-back sweep of every path.
        for (int i = 0; i < 18; i++) begin
            drive(i < 16, (i < 16) ? i : 0);
            s64 = 6'(i * 3);
            step("sweep");
            if (i >= 1 && i <= 16) begin
                chk("sweep_seq", o16, 8'(8'h10 + i - 1));
                chk("sweep_val", 8'(ov16), 8'h01);
            end
        end

        // Out-of-range selects on the padded 6-input tree.
        for (int j = 0; j < 5; j++) begin
            drive(j < 4, (j < 4) ? int'(pad_sel[j]) : 0);
            step("pad");
            if (j >= 1) begin
                chk("pad_data", o6, pad_exp[j-1]);
                chk("pad_val", 8'(ov6), 8'h01);
            end
        end

        // Stall: three cycles with ce low after the second sample.
        held = 8'h00;
        for (int t = 0; t < 10; t++) begin
            ce = st_ce[t];
            drive(st_v[t], st_sel[t]);
            step("stall");
            if (t == 1) held = o16;
            if (!st_ce[t]) chk("stall_hold", o16, held);
            if (st_ce[t] && ov16) q_seen.push_back(o16);
        end
        ce = 1'b1;
        chk("stall_count", 8'(q_seen.size()), 8'd4);
        if (q_seen.size() == 4) begin
            chk("stall_s0", q_seen[0], 8'h12);
            chk("stall_s1", q_seen[1], 8'h15);
            chk("stall_s2", q_seen[2], 8'h18);
            chk("stall_s3", q_seen[3], 8'h1B);
        end

        // Flush while stalled drops in-flight samples.
        drive(1'b1, 3); step("flush_in");
        drive(1'b1, 9); step("flush_in");
        ce = 1'b0; flush = 1'b1; drive(1'b0, 0);
        step("flush");
        chk("flush_clr", 8'(ov16), 8'h00);
        ce = 1'b1; flush = 1'b0;
        drive(1'b1, 12); step("flush_new");
        drive(1'b0, 0);  step("flush_new");
        chk("flush_data", o16, 8'h1C);
        chk("flush_val", 8'(ov16), 8'h01);
        step("flush_tail");
        chk("flush_alone", 8'(ov16), 8'h00);

        // Asynchronous reset between edges with the pipe full.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i + 1);
            step("fill");
        end
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("areset");
        step("areset_hold");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 0);
        step("post_rst");
        step("post_rst");
        drive(1'b1, 7);
        lat16 = 0; lat64 = 0;
        for (int n = 1; n <= 6; n++) begin
            step("rst_lat");
            if (lat16 == 0 && ov16) lat16 = n;
            if (lat64 == 0 && ov64) lat64 = n;
            drive(1'b0, 0);
        end
        chk("rst_lat16", 8'(lat16), 8'd2);
        chk("rst_lat64", 8'(lat64), 8'd1);

        // Randomised traffic with occasional stalls and flushes.
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 4; k++)  d16[k*32 +: 32] = $urandom;
            for (int k = 0; k < 16; k++) d64[k*32 +: 32] = $urandom;
            d6 = {16'($urandom), $urandom};
            s16 = 4'($urandom_range(0, 15)); v16 = 1'($urandom);
            s6  = 4'($urandom_range(0, 15)); v6  = 1'($urandom);
            s64 = 6'($urandom_range(0, 63)); v64 = 1'($urandom);
            ce    = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
